// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_pkg
//  Purpose  : Shared register-window constants for the GPIO responder.
//  Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam int IDX_W        = 3;
  localparam int WINDOW_BYTES = 32;
  localparam int ADDR_LSB     = $clog2(WINDOW_BYTES);

  localparam logic [ADDR_LSB-1:0] OFF_DATA_OUT   = 5'h00;
  localparam logic [ADDR_LSB-1:0] OFF_DIR        = 5'h04;
  localparam logic [ADDR_LSB-1:0] OFF_DATA_IN    = 5'h08;
  localparam logic [ADDR_LSB-1:0] OFF_IRQ_EN     = 5'h0C;
  localparam logic [ADDR_LSB-1:0] OFF_RISE_EN    = 5'h10;
  localparam logic [ADDR_LSB-1:0] OFF_FALL_EN    = 5'h14;
  localparam logic [ADDR_LSB-1:0] OFF_IRQ_STATUS = 5'h18;
  localparam logic [ADDR_LSB-1:0] OFF_TOGGLE     = 5'h1C;

  // Word index of each register, as decoded from A[4:2].
  localparam logic [IDX_W-1:0] IDX_DATA_OUT   = OFF_DATA_OUT[ADDR_LSB-1:2];
  localparam logic [IDX_W-1:0] IDX_DIR        = OFF_DIR[ADDR_LSB-1:2];
  localparam logic [IDX_W-1:0] IDX_DATA_IN    = OFF_DATA_IN[ADDR_LSB-1:2];
  localparam logic [IDX_W-1:0] IDX_IRQ_EN     = OFF_IRQ_EN[ADDR_LSB-1:2];
  localparam logic [IDX_W-1:0] IDX_RISE_EN    = OFF_RISE_EN[ADDR_LSB-1:2];
  localparam logic [IDX_W-1:0] IDX_FALL_EN    = OFF_FALL_EN[ADDR_LSB-1:2];
  localparam logic [IDX_W-1:0] IDX_IRQ_STATUS = OFF_IRQ_STATUS[ADDR_LSB-1:2];
  localparam logic [IDX_W-1:0] IDX_TOGGLE     = OFF_TOGGLE[ADDR_LSB-1:2];

  localparam logic [1:0] WARMUP_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_sync
//  Purpose  : Two-flop input synchroniser with a history flop for edge detect.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign sync_out = r_sync2;
  assign rise     = r_sync2 & ~r_prev;
  assign fall     = ~r_sync2 & r_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_responder
//  Purpose  : Memory-mapped GPIO with direction, edge capture and level IRQ.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_responder
  import gpio_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE,
  input  logic [31:0]      A,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  output logic             hit,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [IDX_W-1:0] w_idx;
  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_capture;

  logic [1:0]       r_warm;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irq_en;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_irq_status;

  assign hit   = (A[31:ADDR_LSB] == BASE_ADDR[31:ADDR_LSB]);
  assign w_idx = A[ADDR_LSB-1:2];
  assign w_wr  = WE & hit;
  assign w_wd  = WD[WIDTH-1:0];

  logic w_unused_addr;
  assign w_unused_addr = ^A[1:0];

  if (WIDTH < 32) begin : g_wd_upper
    logic w_unused_wd;
    assign w_unused_wd = ^WD[31:WIDTH];
  end

  gpio_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (gpio_in),
    .sync_out (w_sync),
    .rise     (w_rise),
    .fall     (w_fall)
  );

  // Edge history is meaningless until the synchroniser has filled after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm <= 2'd0;
    end else if (r_warm != WARMUP_DONE) begin
      r_warm <= r_warm + 2'd1;
    end
  end

  assign w_capture = (r_warm == WARMUP_DONE);
  assign w_set     = w_capture ? ((w_rise & r_rise_en) | (w_fall & r_fall_en)) : '0;
  assign w_clr     = (w_wr && (w_idx == IDX_IRQ_STATUS)) ? w_wd : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_dir        <= '0;
      r_irq_en     <= '0;
      r_rise_en    <= '0;
      r_fall_en    <= '0;
      r_irq_status <= '0;
    end else begin
      r_irq_status <= (r_irq_status & ~w_clr) | w_set;
      if (w_wr) begin
        case (w_idx)
          IDX_DATA_OUT: r_data_out <= w_wd;
          IDX_DIR:      r_dir      <= w_wd;
          IDX_IRQ_EN:   r_irq_en   <= w_wd;
          IDX_RISE_EN:  r_rise_en  <= w_wd;
          IDX_FALL_EN:  r_fall_en  <= w_wd;
          IDX_TOGGLE:   r_data_out <= r_data_out ^ w_wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    RD = '0;
    if (hit) begin
      case (w_idx)
        IDX_DATA_OUT:   RD[WIDTH-1:0] = r_data_out;
        IDX_DIR:        RD[WIDTH-1:0] = r_dir;
        IDX_DATA_IN:    RD[WIDTH-1:0] = w_sync;
        IDX_IRQ_EN:     RD[WIDTH-1:0] = r_irq_en;
        IDX_RISE_EN:    RD[WIDTH-1:0] = r_rise_en;
        IDX_FALL_EN:    RD[WIDTH-1:0] = r_fall_en;
        IDX_IRQ_STATUS: RD[WIDTH-1:0] = r_irq_status;
        default:        RD = '0;
      endcase
    end
  end

  assign gpio_out = r_data_out;
  assign gpio_oe  = r_dir;
  assign irq      = |(r_irq_status & r_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_gpio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_responder
//  Purpose  : Directed plus randomised checks of gpio_responder against a
//             pin-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_responder;

  localparam logic [31:0] C_BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        hit;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  gpio_responder #(
    .WIDTH     (8),
    .BASE_ADDR (C_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .WE       (WE),
    .A        (A),
    .WD       (WD),
    .RD       (RD),
    .hit      (hit),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  pins;
  logic [31:0] rd_seen;
  logic        hit_seen;

  // Reference model: register contents plus the pin values seen at the
  // last three clock edges (h1 newest) and the number of edges since reset.
  logic [7:0] m_out, m_dir, m_ien, m_ren, m_fen, m_stat;
  logic [7:0] h1, h2, h3;
  int         m_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_out = 8'h00; m_dir = 8'h00; m_ien = 8'h00;
    m_ren = 8'h00; m_fen = 8'h00; m_stat = 8'h00;
    h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
    m_edges = 0;
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= C_BASE) && (a < C_BASE + 32'd32);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (m_hit(a)) begin
      case ((a - C_BASE) / 4)
        0: v = m_out;
        1: v = m_dir;
        2: v = h2;      // value seen two edges ago is what the pin reads now
        3: v = m_ien;
        4: v = m_ren;
        5: v = m_fen;
        6: v = m_stat;
        default: v = 8'h00;
      endcase
    end
    return {24'd0, v};
  endfunction

  task automatic m_edge(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] pin);
    logic [7:0] rise, fall, set, clr;
    int off;
    rise = h2 & ~h3;
    fall = ~h2 & h3;
    set  = (m_edges >= 3) ? ((rise & m_ren) | (fall & m_fen)) : 8'h00;
    off  = int'((a - C_BASE) / 4);
    clr  = (we && m_hit(a) && off == 6) ? wd[7:0] : 8'h00;
    m_stat = (m_stat & ~clr) | set;
    if (we && m_hit(a)) begin
      case (off)
        0: m_out = wd[7:0];
        1: m_dir = wd[7:0];
        3: m_ien = wd[7:0];
        4: m_ren = wd[7:0];
        5: m_fen = wd[7:0];
        7: m_out = m_out ^ wd[7:0];
        default: ;
      endcase
    end
    h3 = h2; h2 = h1; h1 = pin;
    m_edges++;
  endtask

  // One clock: drive at negedge, optionally check the read, take the edge,
  // then compare the pin-side outputs against the model.
  task automatic tick(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input bit rd_chk, input string tag);
    @(negedge clk);
    WE = we; A = a; WD = wd; gpio_in = pins;
    #1;
    rd_seen  = RD;
    hit_seen = hit;
    if (rd_chk) begin
      chk({tag, "_rd"}, RD, m_read(a));
      chk({tag, "_hit"}, {31'd0, hit}, {31'd0, m_hit(a)});
    end
    @(posedge clk);
    if (rst) m_reset();
    else     m_edge(we, a, wd, pins);
    #1;
    chk({tag, "_gpio_out"}, {24'd0, gpio_out}, {24'd0, m_out});
    chk({tag, "_gpio_oe"},  {24'd0, gpio_oe},  {24'd0, m_dir});
    chk({tag, "_irq"},      {31'd0, irq},      {31'd0, |(m_stat & m_ien)});
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] wd, input string tag);
    tick(1'b1, C_BASE + {27'd0, off}, wd, 1'b0, tag);
  endtask

  task automatic rd(input logic [4:0] off, input string tag);
    tick(1'b0, C_BASE + {27'd0, off}, 32'd0, 1'b1, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 32'h0, 1'b0, "idle");
  endtask

  logic [31:0] a_r;

  initial begin
    rst = 1'b1; WE = 1'b0; A = 32'h0; WD = 32'h0; pins = 8'h00; gpio_in = 8'h00;
    m_reset();
    idle(2);
    #2 rst = 1'b0;

    // Reset values across the whole window, and an out-of-window read.
    for (int i = 0; i < 8; i++) begin
      rd(5'(i * 4), "reset_read");
      chk("reset_rd_zero", rd_seen, 32'h0);
    end
    tick(1'b0, 32'h0000_2000, 32'h0, 1'b1, "miss");
    chk("miss_rd", rd_seen, 32'h0);
    chk("miss_hit", {31'd0, hit_seen}, 32'd0);

    // Output/direction and toggle.
    wr(5'h04, 32'h0000_00FF, "w_dir");
    wr(5'h00, 32'hFFFF_FFA5, "w_out");
    wr(5'h1C, 32'h0000_000F, "w_tog");
    chk("tog_gpio_out", {24'd0, gpio_out}, 32'h0000_00AA);
    chk("tog_gpio_oe", {24'd0, gpio_oe}, 32'h0000_00FF);
    rd(5'h00, "rb_out");
    chk("rb_out_val", rd_seen, 32'h0000_00AA);
    rd(5'h1C, "rb_tog");
    chk("rb_tog_val", rd_seen, 32'h0);

    // Rise capture latency.
    wr(5'h10, 32'h1, "w_ren");
    wr(5'h0C, 32'h1, "w_ien");
    pins = 8'h01;
    idle(1);                           // edge N
    rd(5'h08, "lat_n1");               // edge N+1
    chk("lat_datain_before", rd_seen, 32'h0);
    chk("lat_irq_n1", {31'd0, irq}, 32'd0);
    rd(5'h08, "lat_n2");               // edge N+2
    chk("lat_datain_after", rd_seen, 32'h1);
    chk("lat_irq_n2", {31'd0, irq}, 32'd1);
    rd(5'h18, "lat_stat");
    chk("lat_stat_val", rd_seen, 32'h1);
    wr(5'h18, 32'h1, "w1c");
    chk("w1c_irq", {31'd0, irq}, 32'd0);

    // Set wins over a simultaneous W1C.
    wr(5'h14, 32'h80, "w_fen");
    pins = 8'h81;
    idle(4);
    wr(5'h18, 32'hFF, "clr_all");
    pins = 8'h01;
    idle(2);                           // edges N, N+1
    wr(5'h18, 32'h80, "w1c_race");     // edge N+2: fall set collides with clear
    rd(5'h18, "race_stat");
    chk("set_wins", rd_seen & 32'h80, 32'h80);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
      else if ($urandom_range(0, 7) == 0) pins = ~pins;
      if ($urandom_range(0, 7) == 0) a_r = $urandom;
      else a_r = C_BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      tick(($urandom_range(0, 2) == 0), a_r, $urandom, 1'b1, "rand");
    end

    // Pins held high through reset must not produce rise events.
    pins = 8'hFF;
    rst = 1'b1;
    m_reset();
    idle(3);
    #2 rst = 1'b0;
    wr(5'h10, 32'hFF, "warm_ren");
    idle(6);
    rd(5'h18, "warm_stat");
    chk("warm_stat_zero", rd_seen, 32'h0);
    rd(5'h08, "warm_datain");
    chk("warm_datain_ff", rd_seen, 32'hFF);

    // Asynchronous reset mid-operation.
    wr(5'h00, 32'h3C, "mr_out");
    wr(5'h04, 32'hFF, "mr_dir");
    wr(5'h0C, 32'hFF, "mr_ien");
    wr(5'h14, 32'hFF, "mr_fen");
    pins = 8'hF0;
    idle(3);
    chk("mr_irq_before", {31'd0, irq}, 32'd1);
    A = C_BASE;
    WE = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_gpio_out", {24'd0, gpio_out}, 32'h0);
    chk("mr_gpio_oe", {24'd0, gpio_oe}, 32'h0);
    chk("mr_irq", {31'd0, irq}, 32'd0);
    chk("mr_rd", RD, 32'h0);
    m_reset();
    idle(2);
    #2 rst = 1'b0;
    rd(5'h00, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
